// File: rtl/shifter_defs.sv
// Shared definitions for the execute-stage shifter path: op codes, the
// arbiter FSM state encoding and the requester-id width helper. The
// shifter and the decoder use the same op codes.
//
// Contents
//   SH_SRL/SH_SRA/SH_SLL/SH_ROR  2-bit shifter op codes
//   sa_state_t                   shift_arbiter FSM states
//   id_width()                   requester-id width, minimum 1 bit
package shifter_defs;

    localparam logic [1:0] SH_SRL = 2'b00;
    localparam logic [1:0] SH_SRA = 2'b01;
    localparam logic [1:0] SH_SLL = 2'b10;
    localparam logic [1:0] SH_ROR = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_EXEC  = 2'd1,
        ST_PASS2 = 2'd2,
        ST_RESP  = 2'd3
    } sa_state_t;

    function automatic int id_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin grant generator with its own rotating pointer. The search
// starts at the pointer and wraps; when the caller reports that the grant
// was taken (advance), the pointer moves to the slot after the winner.
//
// Ports
//   clock, reset_n  clock and asynchronous active-low reset
//   req             per-requester valid
//   advance         the current grant was accepted this cycle
//   grant           one-hot grant (zero when no request)
//   grant_id        index of the granted requester
//   any             at least one request present
module rr_arbiter #(
    parameter int NREQ = 2,
    parameter int IDW  = 1
) (
    input  logic            clock,
    input  logic            reset_n,
    input  logic [NREQ-1:0] req,
    input  logic            advance,
    output logic [NREQ-1:0] grant,
    output logic [IDW-1:0]  grant_id,
    output logic            any
);

    logic [IDW-1:0] ptr_q;
    logic [IDW-1:0] ptr_d;

    always_comb begin
        grant    = '0;
        grant_id = '0;
        any      = 1'b0;
        for (int off = 0; off < NREQ; off++) begin
            int cand;
            cand = (int'(ptr_q) + off) % NREQ;
            for (int i = 0; i < NREQ; i++) begin
                if (!any && (i == cand) && req[i]) begin
                    any      = 1'b1;
                    grant[i] = 1'b1;
                    grant_id = IDW'(i);
                end
            end
        end
    end

    always_comb begin
        ptr_d = ptr_q;
        if (advance) begin
            ptr_d = (grant_id == IDW'(NREQ - 1)) ? '0 : grant_id + 1'b1;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/shift_arbiter.sv
// Shares one external barrel shifter between NREQ requesters. A request is
// granted round-robin, its operands are registered, the shifter is driven
// from those registers for one cycle and its result is returned tagged with
// the requester id.
//
// Build option: define ROTATE_EN to implement op 11 as rotate-right in two
// shifter passes (SRL amt, then SLL 32-amt, OR-ed). Without it op 11 is
// accepted, never sent to the shifter, and answered with resp_err=1, data 0.
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both high. req_ready is combinational from req_valid/resp_ready; requesters
// must hold req_valid without looking at req_ready. resp_* hold while
// resp_valid=1 and resp_ready=0.
//
// Ports
//   clock, reset_n        clock, asynchronous active-low reset
//   req_valid/req_ready   per-requester request handshake
//   req_op/amt/data       packed per-requester op (2b), amount (5b), data (32b)
//   resp_valid/ready      response handshake
//   resp_id/data/err      owning requester, result, illegal-op flag
//   sh_in/sh_op/sh_amt    drive to the external shifter (zero when idle)
//   sh_result             combinational shifter result
//   dbg_state             current FSM state (sa_state_t encoding)
module shift_arbiter
    import shifter_defs::*;
#(
    parameter int   NREQ = 2,
    localparam int  IDW  = id_width(NREQ)
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic [NREQ-1:0]   req_valid,
    output logic [NREQ-1:0]   req_ready,
    input  logic [2*NREQ-1:0] req_op,
    input  logic [5*NREQ-1:0] req_amt,
    input  logic [32*NREQ-1:0] req_data,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [IDW-1:0]    resp_id,
    output logic [31:0]       resp_data,
    output logic              resp_err,
    output logic [31:0]       sh_in,
    output logic [1:0]        sh_op,
    output logic [4:0]        sh_amt,
    input  logic [31:0]       sh_result,
    output logic [1:0]        dbg_state
);

    sa_state_t      state_q, state_d;
    logic [1:0]     op_q, op_d;
    logic [4:0]     amt_q, amt_d;
    logic [31:0]    data_q, data_d;
    logic [IDW-1:0] id_q, id_d;
    logic [IDW-1:0] resp_id_q, resp_id_d;
    logic [31:0]    resp_data_q, resp_data_d;
    logic           resp_err_q, resp_err_d;
`ifdef ROTATE_EN
    logic [31:0]    partial_q, partial_d;
`endif

    logic [NREQ-1:0] grant;
    logic [IDW-1:0]  grant_id;
    logic            any_valid;
    logic            can_accept;
    logic            accept;
    logic [1:0]      sel_op;
    logic [4:0]      sel_amt;
    logic [31:0]     sel_data;

    // reset_n in the gate keeps req_ready low while reset is held.
    assign can_accept = reset_n &&
                        ((state_q == ST_IDLE) || ((state_q == ST_RESP) && resp_ready));
    assign accept     = can_accept && any_valid;
    assign req_ready  = can_accept ? grant : '0;

    rr_arbiter #(.NREQ(NREQ), .IDW(IDW)) u_rr (
        .clock    (clock),
        .reset_n  (reset_n),
        .req      (req_valid),
        .advance  (accept),
        .grant    (grant),
        .grant_id (grant_id),
        .any      (any_valid)
    );

    always_comb begin
        sel_op   = '0;
        sel_amt  = '0;
        sel_data = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (grant_id == IDW'(i)) begin
                sel_op   = req_op[2*i +: 2];
                sel_amt  = req_amt[5*i +: 5];
                sel_data = req_data[32*i +: 32];
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        amt_d       = amt_q;
        data_d      = data_q;
        id_d        = id_q;
        resp_id_d   = resp_id_q;
        resp_data_d = resp_data_q;
        resp_err_d  = resp_err_q;
`ifdef ROTATE_EN
        partial_d   = partial_q;
`endif
        sh_in       = '0;
        sh_op       = SH_SRL;
        sh_amt      = '0;

        if (accept) begin
            op_d   = sel_op;
            amt_d  = sel_amt;
            data_d = sel_data;
            id_d   = grant_id;
        end

        case (state_q)
            ST_IDLE: begin
                if (accept) state_d = ST_EXEC;
            end
            ST_EXEC: begin
                resp_id_d = id_q;
                resp_err_d = 1'b0;
                state_d = ST_RESP;
                if (op_q == SH_ROR) begin
`ifdef ROTATE_EN
                    // First pass: logical right shift, kept as the low part.
                    sh_op     = SH_SRL;
                    sh_amt    = amt_q;
                    sh_in     = data_q;
                    partial_d = sh_result;
                    if (amt_q == 5'd0) begin
                        resp_data_d = data_q;
                    end else begin
                        state_d = ST_PASS2;
                    end
`else
                    resp_data_d = '0;
                    resp_err_d  = 1'b1;
`endif
                end else begin
                    sh_op       = op_q;
                    sh_amt      = amt_q;
                    sh_in       = data_q;
                    resp_data_d = sh_result;
                end
            end
`ifdef ROTATE_EN
            ST_PASS2: begin
                // 5-bit negate gives (32 - amt) mod 32; amt is nonzero here.
                sh_op       = SH_SLL;
                sh_amt      = 5'd0 - amt_q;
                sh_in       = data_q;
                resp_data_d = partial_q | sh_result;
                state_d     = ST_RESP;
            end
`endif
            ST_RESP: begin
                if (resp_ready) state_d = accept ? ST_EXEC : ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            op_q        <= '0;
            amt_q       <= '0;
            data_q      <= '0;
            id_q        <= '0;
            resp_id_q   <= '0;
            resp_data_q <= '0;
            resp_err_q  <= 1'b0;
`ifdef ROTATE_EN
            partial_q   <= '0;
`endif
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            amt_q       <= amt_d;
            data_q      <= data_d;
            id_q        <= id_d;
            resp_id_q   <= resp_id_d;
            resp_data_q <= resp_data_d;
            resp_err_q  <= resp_err_d;
`ifdef ROTATE_EN
            partial_q   <= partial_d;
`endif
        end
    end

    assign resp_valid = (state_q == ST_RESP);
    assign resp_id    = resp_id_q;
    assign resp_data  = resp_data_q;
    assign resp_err   = resp_err_q;
    assign dbg_state  = state_q;

endmodule

// File: tb/tb_shift_arbiter.sv
// Bench for shift_arbiter with NREQ=2 and a behavioural shifter. Requester
// queues feed the DUT; a reference model predicts each response (data, id,
// error flag and the cycle it must appear) and the grant each cycle.
module tb_shift_arbiter;

    logic        clock;
    logic        reset_n;
    logic [1:0]  req_valid;
    logic [1:0]  req_ready;
    logic [3:0]  req_op;
    logic [9:0]  req_amt;
    logic [63:0] req_data;
    logic        resp_valid;
    logic        resp_ready;
    logic [0:0]  resp_id;
    logic [31:0] resp_data;
    logic        resp_err;
    logic [31:0] sh_in;
    logic [1:0]  sh_op;
    logic [4:0]  sh_amt;
    logic [31:0] sh_result;
    logic [1:0]  dbg_state;

`ifdef ROTATE_EN
    localparam bit ROT = 1'b1;
`else
    localparam bit ROT = 1'b0;
`endif

    shift_arbiter #(.NREQ(2)) dut (
        .clock(clock), .reset_n(reset_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_op(req_op), .req_amt(req_amt), .req_data(req_data),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_id(resp_id), .resp_data(resp_data), .resp_err(resp_err),
        .sh_in(sh_in), .sh_op(sh_op), .sh_amt(sh_amt),
        .sh_result(sh_result), .dbg_state(dbg_state)
    );

    // clock / reset
    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    int cyc = 0;
    initial forever begin
        @(posedge clock);
        cyc++;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached, got no end, required end");
        $fatal(1);
    end

    // external shifter
    always_comb begin
        case (sh_op)
            2'b00:   sh_result = sh_in >> sh_amt;
            2'b01:   sh_result = $unsigned($signed(sh_in) >>> sh_amt);
            2'b10:   sh_result = sh_in << sh_amt;
            default: sh_result = 32'hDEAD_BEEF;
        endcase
    end

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h required %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // reference model: returns {err, data}
    function automatic logic [32:0] model(input logic [1:0] op, input logic [4:0] amt,
                                         input logic [31:0] d);
        logic signed [31:0] s;
        logic [63:0] dd;
        s  = d;
        dd = {d, d} >> amt;
        case (op)
            2'b00:   return {1'b0, d >> amt};
            2'b01:   return {1'b0, 32'(s >>> amt)};
            2'b10:   return {1'b0, d << amt};
            default: return ROT ? {1'b0, dd[31:0]} : {1'b1, 32'h0};
        endcase
    endfunction

    // scoreboard
    typedef struct packed {
        logic [31:0] due;
        logic        err;
        logic        id;
        logic [31:0] data;
    } exp_t;

    exp_t        exp_q[$];
    int          grant_log[$];
    int          resp_log[$];
    int          mptr = 0;
    int          acc0 = 0, acc1 = 0;
    int          n_acc = 0, n_resp = 0;
    int          last_acc_cyc = 0;
    logic [31:0] last_data;
    logic        last_id;
    logic        last_err;

    initial forever begin
        bit          ev, pop, can;
        int          gid;
        logic [1:0]  erdy;
        logic [32:0] m;
        exp_t        e;
        @(negedge clock);
        if (!reset_n) begin
            exp_q.delete();
            mptr = 0;
        end else begin
            ev = (exp_q.size() != 0) && (cyc >= int'(exp_q[0].due));
            chk("resp_valid", {63'b0, resp_valid}, {63'b0, ev});
            if (ev) begin
                chk("resp_data", {32'b0, resp_data}, {32'b0, exp_q[0].data});
                chk("resp_id", {63'b0, resp_id}, {63'b0, exp_q[0].id});
                chk("resp_err", {63'b0, resp_err}, {63'b0, exp_q[0].err});
            end
            chk("sh_op_legal", {63'b0, sh_op == 2'b11}, 64'd0);
            pop = ev && resp_ready;
            can = (exp_q.size() == 0) || ((exp_q.size() == 1) && pop);
            gid = -1;
            for (int k = 0; k < 2; k++) begin
                int c;
                c = (mptr + k) % 2;
                if (gid < 0 && req_valid[c[0]]) gid = c;
            end
            erdy = (can && gid >= 0) ? (2'b01 << gid) : 2'b00;
            chk("req_ready", {62'b0, req_ready}, {62'b0, erdy});
            if (pop) begin
                last_data = exp_q[0].data;
                last_id   = exp_q[0].id;
                last_err  = exp_q[0].err;
                resp_log.push_back(int'(exp_q[0].id));
                n_resp++;
                void'(exp_q.pop_front());
            end
            for (int i = 0; i < 2; i++) begin
                if (req_valid[i] && req_ready[i]) begin
                    m      = model(req_op[2*i +: 2], req_amt[5*i +: 5], req_data[32*i +: 32]);
                    e.err  = m[32];
                    e.data = m[31:0];
                    e.id   = i[0];
                    e.due  = 32'(cyc + ((req_op[2*i +: 2] == 2'b11 && ROT &&
                                         req_amt[5*i +: 5] != 5'd0) ? 3 : 2));
                    exp_q.push_back(e);
                    grant_log.push_back(i);
                    mptr = (i + 1) % 2;
                    last_acc_cyc = cyc;
                    n_acc++;
                    if (i == 0) acc0++; else acc1++;
                end
            end
        end
    end

    // driver
    logic [38:0] q0[$];
    logic [38:0] q1[$];
    int pop0 = 0, pop1 = 0;

    task automatic push(input int r, input logic [1:0] op, input logic [4:0] amt,
                        input logic [31:0] d);
        if (r == 0) q0.push_back({op, amt, d});
        else        q1.push_back({op, amt, d});
    endtask

    task automatic apply();
        logic [38:0] w0, w1;
        while (pop0 < acc0) begin void'(q0.pop_front()); pop0++; end
        while (pop1 < acc1) begin void'(q1.pop_front()); pop1++; end
        w0 = (q0.size() != 0) ? q0[0] : '0;
        w1 = (q1.size() != 0) ? q1[0] : '0;
        req_valid = {q1.size() != 0, q0.size() != 0};
        req_op    = {w1[38:37], w0[38:37]};
        req_amt   = {w1[36:32], w0[36:32]};
        req_data  = {w1[31:0],  w0[31:0]};
    endtask

    task automatic step();
        @(posedge clock);
        #1;
        apply();
    endtask

    task automatic drain(input int max);
        int n;
        n = 0;
        while ((q0.size() != 0 || q1.size() != 0 || exp_q.size() != 0) && n < max) begin
            step();
            n++;
        end
        if (q0.size() != 0 || q1.size() != 0 || exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout: got %0d pending, required 0", exp_q.size());
        end
    endtask

    initial begin
        int base, nb, rc, nr;
        reset_n    = 1'b0;
        resp_ready = 1'b1;
        req_valid  = 2'b11;
        req_op     = '0;
        req_amt    = '0;
        req_data   = '1;
        repeat (3) @(posedge clock);
        #1;
        chk("rst_req_ready", {62'b0, req_ready}, 64'd0);
        chk("rst_resp_valid", {63'b0, resp_valid}, 64'd0);
        chk("rst_resp_id", {63'b0, resp_id}, 64'd0);
        chk("rst_resp_data", {32'b0, resp_data}, 64'd0);
        chk("rst_resp_err", {63'b0, resp_err}, 64'd0);
        chk("rst_sh_in", {32'b0, sh_in}, 64'd0);
        chk("rst_sh_op", {62'b0, sh_op}, 64'd0);
        chk("rst_sh_amt", {59'b0, sh_amt}, 64'd0);
        chk("rst_state", {62'b0, dbg_state}, 64'd0);
        req_valid = 2'b00;
        req_data  = '0;
        #3 reset_n = 1'b1;

        // pin the model with hand-computed values
        chk("model_srl", {31'b0, model(2'b00, 5'd4, 32'h8000_0000)}, {31'b0, 1'b0, 32'h0800_0000});
        chk("model_sra", {31'b0, model(2'b01, 5'd31, 32'h8000_0000)}, {31'b0, 1'b0, 32'hFFFF_FFFF});
        chk("model_sll", {31'b0, model(2'b10, 5'd31, 32'h0000_0001)}, {31'b0, 1'b0, 32'h8000_0000});
        chk("model_ror", {31'b0, model(2'b11, 5'd8, 32'h1234_5678)},
            ROT ? {31'b0, 1'b0, 32'h7812_3456} : {31'b0, 1'b1, 32'h0});

        // single operations
        push(0, 2'b00, 5'd4, 32'h8000_0000); drain(40);
        chk("srl_data", {32'b0, last_data}, {32'b0, 32'h0800_0000});
        chk("srl_id", {63'b0, last_id}, 64'd0);
        push(1, 2'b01, 5'd31, 32'h8000_0000); drain(40);
        chk("sra_data", {32'b0, last_data}, {32'b0, 32'hFFFF_FFFF});
        chk("sra_id", {63'b0, last_id}, 64'd1);
        push(1, 2'b10, 5'd31, 32'h0000_0001); drain(40);
        chk("sll_data", {32'b0, last_data}, {32'b0, 32'h8000_0000});
        push(1, 2'b01, 5'd0, 32'h8765_4321); drain(40);
        chk("sra_amt0", {32'b0, last_data}, {32'b0, 32'h8765_4321});

        // contention: both requesters hold 4 ops each
        base = grant_log.size();
        rc   = resp_log.size();
        for (int k = 0; k < 4; k++) begin
            push(0, 2'($urandom_range(0, 2)), 5'($urandom_range(0, 31)), $urandom);
            push(1, 2'($urandom_range(0, 2)), 5'($urandom_range(0, 31)), $urandom);
        end
        drain(100);
        chk("cont_count", 64'(grant_log.size() - base), 64'd8);
        for (int k = 0; k < 8; k++) begin
            if (base + k < grant_log.size()) chk("cont_grant", 64'(grant_log[base + k]), 64'(k % 2));
            if (rc + k < resp_log.size())    chk("cont_resp_id", 64'(resp_log[rc + k]), 64'(k % 2));
        end

        // backpressure
        resp_ready = 1'b0;
        nb = n_acc;
        push(0, 2'b00, 5'd4, 32'h0000_00F0);
        push(1, 2'b10, 5'd2, 32'h0000_0003);
        repeat (9) step();
        chk("bp_one_accept", 64'(n_acc - nb), 64'd1);
        chk("bp_resp_held", {63'b0, resp_valid}, 64'd1);
        chk("bp_resp_data", {32'b0, resp_data}, {32'b0, 32'h0000_000F});
        nr = cyc;
        resp_ready = 1'b1;
        step();
        chk("bp_same_cycle_accept", 64'(last_acc_cyc), 64'(nr));
        drain(40);
        chk("bp_second_data", {32'b0, last_data}, {32'b0, 32'h0000_000C});
        chk("bp_second_id", {63'b0, last_id}, 64'd1);

        // rotate / illegal op
        push(0, 2'b11, 5'd8, 32'h1234_5678); drain(40);
        chk("ror8_data", {32'b0, last_data}, ROT ? {32'b0, 32'h7812_3456} : 64'd0);
        chk("ror8_err", {63'b0, last_err}, ROT ? 64'd0 : 64'd1);
        push(0, 2'b11, 5'd0, 32'h1234_5678); drain(40);
        chk("ror0_data", {32'b0, last_data}, ROT ? {32'b0, 32'h1234_5678} : 64'd0);

        // reset during EXEC
        push(0, 2'b00, 5'd1, 32'h0000_AAAA);
        nr = 0;
        step();
        while (dbg_state != 2'd1 && nr < 10) begin step(); nr++; end
        chk("reached_exec", {62'b0, dbg_state}, 64'd1);
        #2 reset_n = 1'b0;
        #1;
        chk("mid_rst_state", {62'b0, dbg_state}, 64'd0);
        chk("mid_rst_valid", {63'b0, resp_valid}, 64'd0);
        chk("mid_rst_sh_op", {62'b0, sh_op}, 64'd0);
        nr = n_resp;
        repeat (2) step();
        #3 reset_n = 1'b1;
        base = grant_log.size();
        push(0, 2'b10, 5'd4, 32'h0000_0011);
        push(1, 2'b00, 5'd4, 32'h0000_0110);
        drain(40);
        chk("post_rst_resp_count", 64'(n_resp - nr), 64'd2);
        if (grant_log.size() >= base + 2) begin
            chk("post_rst_first_grant", 64'(grant_log[base]), 64'd0);
            chk("post_rst_second_grant", 64'(grant_log[base + 1]), 64'd1);
        end else begin
            chk("post_rst_grants", 64'(grant_log.size() - base), 64'd2);
        end
        chk("post_rst_data", {32'b0, last_data}, {32'b0, 32'h0000_0011});

        repeat (3) step();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
